// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix add/subtract controller.
// Holds the controller state encoding, default geometry (5x5 matrix,
// 5-bit element index) and the element data width.
package matrix_pkg;

  localparam int ELEMS_DEFAULT = 25;
  localparam int AW_DEFAULT    = 5;
  localparam int DW            = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_addsub_ctrl.sv
// Element-wise A+B / A-B controller for ELEMS-element matrices.
// Streams element indices to the A and B operand memories, feeds each
// pair through an external shared 8-bit adder (subtract = A + ~B + 1),
// and writes the sums to a result memory in index order at one element
// per cycle. Tracks sticky signed overflow for the current operation.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, op_sub       operation request (IDLE only), 0 = add, 1 = sub
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   rd_en, rd_addr      operand read strobe / element index
//   a_data, b_data      operands, valid the cycle after rd_en
//   add_r1/r2/cin       operands to the external adder
//   add_s, add_cout     adder sum (combinational), carry-out (unused)
//   wr_en/addr/data     result write port
//   ovf                 sticky signed overflow, cleared at each start
module matrix_addsub_ctrl
  import matrix_pkg::*;
#(
  parameter int ELEMS = ELEMS_DEFAULT,
  parameter int AW    = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          op_sub,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] a_data,
  input  logic [DW-1:0] b_data,
  output logic [DW-1:0] add_r1,
  output logic [DW-1:0] add_r2,
  output logic          add_cin,
  input  logic [DW-1:0] add_s,
  input  logic          add_cout,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          ovf
);

  localparam logic [AW-1:0] LAST_IDX = AW'(ELEMS - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_idx;
  logic          r_op;
  logic          r_drain_cnt;
  logic          r_s1_valid;
  logic [AW-1:0] r_s1_idx;
  logic          w_accept;
  logic          w_ovf_hit;

  // Carry-out has no role in the result or the overflow flag.
  logic w_unused_cout;
  assign w_unused_cout = add_cout;

  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) is reserved for combinational blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    rd_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        rd_en = 1'b1;
        if (r_idx == LAST_IDX) w_next = ST_DRAIN;
      end
      // Two cycles let the last element clear stage 1 and the write stage.
      ST_DRAIN: if (r_drain_cnt) w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign rd_addr = r_idx;

  // Stage 1: operands arrive the cycle after rd_en. Subtraction is done
  // as A + ~B + 1; the adder inputs are forced to zero when idle.
  always_comb begin
    add_r1  = '0;
    add_r2  = '0;
    add_cin = 1'b0;
    if (r_s1_valid) begin
      add_r1  = a_data;
      add_r2  = r_op ? ~b_data : b_data;
      add_cin = r_op;
    end
  end

  // Signed overflow: same-sign operands producing a different-sign sum.
  assign w_ovf_hit = r_s1_valid && (add_r1[DW-1] == add_r2[DW-1])
                     && (add_s[DW-1] != add_r1[DW-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_op        <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s1_idx    <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      ovf         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op  <= op_sub;
        r_idx <= '0;
      end else if (rd_en && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + 1'b1;
      end

      r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;

      r_s1_valid <= rd_en;
      r_s1_idx   <= r_idx;

      wr_en <= r_s1_valid;
      if (r_s1_valid) begin
        wr_data <= add_s;
        wr_addr <= r_s1_idx;
      end

      if (w_accept)       ovf <= 1'b0;
      else if (w_ovf_hit) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_matrix_addsub_ctrl.sv
// Self-checking bench for matrix_addsub_ctrl: operand memories and the
// external adder are modelled here; expected results come from plain
// modulo-256 arithmetic and signed range checks on the memory contents.
module tb_matrix_addsub_ctrl;

  localparam int E  = 25;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op_sub = 1'b0;
  logic          busy, done, rd_en, wr_en, ovf, add_cin, add_cout;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [7:0]    a_data = '0, b_data = '0;
  logic [7:0]    add_r1, add_r2, add_s, wr_data;

  matrix_addsub_ctrl #(.ELEMS(E), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_data(a_data), .b_data(b_data),
    .add_r1(add_r1), .add_r2(add_r2), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Operand memories (one-cycle read latency) and the external adder.
  logic [7:0] mem_a [0:31];
  logic [7:0] mem_b [0:31];
  always @(posedge clk) if (rd_en) begin
    a_data <= mem_a[rd_addr];
    b_data <= mem_b[rd_addr];
  end
  assign {add_cout, add_s} = {1'b0, add_r1} + {1'b0, add_r2} + {8'd0, add_cin};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  bit mon_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: cycle numbers are relative to the edge that sampled start (cycle 1 follows it).
  int wq_addr[$], wq_data[$], wq_cyc[$], done_q[$];
  int rd_cnt, rd_first, rd_bad, ovf_rise;
  logic busy_at [0:79];
  logic ovf_at  [0:79];
  always @(negedge clk) if (mon_on) begin
    int c;
    c = cyc - t0 + 1;
    if (c >= 0 && c < 80) begin
      busy_at[c] = busy;
      ovf_at[c]  = ovf;
    end
    if (wr_en) begin
      wq_addr.push_back(int'(wr_addr));
      wq_data.push_back(int'(wr_data));
      wq_cyc.push_back(c);
    end
    if (rd_en) begin
      if (rd_cnt == 0) rd_first = c;
      if (int'(rd_addr) != rd_cnt % E) rd_bad++;
      rd_cnt++;
    end
    if (done) done_q.push_back(c);
    if (ovf && c >= 1 && ovf_rise < 0) ovf_rise = c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_res(input bit op, input logic [7:0] a, input logic [7:0] b);
    int r;
    r = op ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    return ((r % 256) + 256) % 256;
  endfunction

  function automatic bit ref_ovf(input bit op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = op ? (sa - sb) : (sa + sb);
    return (r > 127) || (r < -128);
  endfunction

  task automatic clear_mon();
    wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); done_q.delete();
    rd_cnt = 0; rd_first = -1; rd_bad = 0; ovf_rise = -1;
  endtask

  // Writes for one operation starting at queue entry q0, first write in cycle c0.
  task automatic check_writes(input string tag, input bit op, input int q0, input int c0);
    for (int j = 0; j < E; j++) begin
      if (q0 + j < wq_addr.size()) begin
        check($sformatf("%s wr%0d addr", tag, j), wq_addr[q0+j], j);
        check($sformatf("%s wr%0d data", tag, j), wq_data[q0+j], ref_res(op, mem_a[j], mem_b[j]));
        check($sformatf("%s wr%0d cycle", tag, j), wq_cyc[q0+j], c0 + j);
      end
    end
  endtask

  task automatic check_run(input string tag, input bit op);
    int first_ov;
    first_ov = -1;
    for (int j = 0; j < E; j++)
      if (first_ov < 0 && ref_ovf(op, mem_a[j], mem_b[j])) first_ov = j;
    check({tag, " write count"}, wq_addr.size(), E);
    check_writes(tag, op, 0, 3);
    check({tag, " read count"}, rd_cnt, E);
    check({tag, " first read cycle"}, rd_first, 1);
    check({tag, " read order"}, rd_bad, 0);
    check({tag, " done count"}, done_q.size(), 1);
    if (done_q.size() > 0) check({tag, " done cycle"}, done_q[0], 28);
    check({tag, " ovf clear at start"}, ovf_at[1], 1'b0);
    check({tag, " ovf rise cycle"}, ovf_rise, (first_ov < 0) ? -1 : 3 + first_ov);
    check({tag, " ovf held"}, ovf, first_ov >= 0);
    check({tag, " idle after"}, busy, 1'b0);
  endtask

  // One operation; extra start pulses in cycles p1/p2; op_sub is scrambled while busy.
  task automatic run_op(input string tag, input bit op, input int p1, input int p2);
    int c;
    clear_mon();
    @(negedge clk);
    t0 = cyc + 1; start = 1'b1; op_sub = op; mon_on = 1'b1;
    do begin
      @(negedge clk);
      c = cyc - t0 + 1;
      start  = (c == p1) || (c == p2);
      op_sub = 1'($urandom);
    end while (c < 40);
    start = 1'b0; mon_on = 1'b0;
    check_run(tag, op);
  endtask

  task automatic fill_add();
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'(2 * i);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " ctrl outputs"}, {26'd0, busy, done, rd_en, wr_en, ovf, add_cin}, 32'd0);
    check({tag, " addr/data outputs"}, {14'd0, rd_addr, wr_addr, wr_data}, 32'd0);
    check({tag, " adder operands"}, {16'd0, add_r1, add_r2}, 32'd0);
  endtask

  initial begin
    int c;
    fill_add();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", busy, 1'b0);

    // Add A[i]=i, B[i]=2i; extra starts in cycles 5 and 27 are ignored.
    run_op("add", 1'b0, 5, 27);

    // Subtract 10 - i; start in the DONE cycle is ignored.
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 8'd10;
      mem_b[i] = 8'(i);
    end
    run_op("sub", 1'b1, 28, -1);
    check("sub i=24 value", (wq_data.size() == E) ? wq_data[24] : -1, 32'hF2);

    // Signed overflow at index 7.
    fill_add();
    mem_a[7] = 8'h7F;
    mem_b[7] = 8'h01;
    run_op("ovf", 1'b0, -1, -1);
    check("ovf i=7 value", (wq_data.size() == E) ? wq_data[7] : -1, 32'h80);

    // Random operands and operation.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] = 8'($urandom);
        mem_b[i] = 8'($urandom);
      end
      run_op($sformatf("rand%0d", r), 1'($urandom), -1, -1);
    end

    // Reset in the middle of a run.
    fill_add();
    clear_mon();
    @(negedge clk);
    t0 = cyc + 1; start = 1'b1; op_sub = 1'b0; mon_on = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("mid-run reset");
    clear_mon();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle after abort", busy, 1'b0);
    repeat (10) @(negedge clk);
    mon_on = 1'b0;
    check("no writes after reset", wq_addr.size(), 0);
    run_op("post-reset", 1'b0, -1, -1);

    // Back-to-back: start held; second op (sub) accepted in the IDLE cycle after DONE.
    mem_a[7] = 8'h7F;
    mem_b[7] = 8'h01;
    clear_mon();
    @(negedge clk);
    t0 = cyc + 1; start = 1'b1; op_sub = 1'b0; mon_on = 1'b1;
    do begin
      @(negedge clk);
      c = cyc - t0 + 1;
      start  = (c < 30);
      op_sub = (c >= 29);
    end while (c < 70);
    start = 1'b0; mon_on = 1'b0;
    check("b2b write count", wq_addr.size(), 2 * E);
    check_writes("b2b op1", 1'b0, 0, 3);
    check_writes("b2b op2", 1'b1, E, 32);
    check("b2b done count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("b2b done1 cycle", done_q[0], 28);
      check("b2b done2 cycle", done_q[1], 57);
    end
    check("b2b busy in DONE", busy_at[28], 1'b1);
    check("b2b idle gap", busy_at[29], 1'b0);
    check("b2b restart busy", busy_at[30], 1'b1);
    check("b2b ovf before restart", ovf_at[29], 1'b1);
    check("b2b ovf cleared at start", ovf_at[30], 1'b0);
    check("b2b ovf end", ovf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
